turnos_control: RTL

Battleship game sequencer. Gates the ship-placement phase, then alternates firing turns between the human player and the CPU opponent. Each shot goes through a valid/done handshake to the board-update logic, and the block counts hits per side to declare a winner. It sits above the placement block (drives its enable, consumes its done flag) and the board/shot-resolution logic.

---
 rtl/turnos_control.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/turnos_control.sv
// Battleship turn sequencer: gates ship placement, alternates player/CPU shots through a
// valid/done handshake with the board logic, and counts hits per side to declare a winner.
module turnos_control #(
   parameter int unsigned TURN_CYCLES = 8,
   parameter int unsigned SHIP_CELLS  = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       end_move_barcos,
   output logic       en_put_barcos,
   input  logic       player_fire,
   input  logic [2:0] player_x,
   input  logic [2:0] player_y,
   output logic       cpu_req,
   input  logic       cpu_valid,
   input  logic [2:0] cpu_x,
   input  logic [2:0] cpu_y,
   output logic       shot_valid,
   output logic [2:0] shot_x,
   output logic [2:0] shot_y,
   output logic       shot_target,
   input  logic       shot_done,
   input  logic       shot_hit,
   output logic [3:0] hits_player,
   output logic [3:0] hits_cpu,
   output logic       turn,
   output logic       turn_timeout,
   output logic       game_over,
   output logic       winner
);

   localparam int unsigned   TW         = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_CYCLES - 1);
   localparam logic [3:0]    HIT_WIN    = 4'(SHIP_CELLS);

   typedef enum logic [2:0] {
      StIdle,
      StPlace,
      StPlayerTurn,
      StPlayerShot,
      StCpuTurn,
      StCpuShot,
      StGameOver
   } state_e;

   state_e        state_q;
   logic [TW-1:0] timer_q;
   logic          player_ok;
   logic          cpu_ok;
   logic [3:0]    hits_player_inc;
   logic [3:0]    hits_cpu_inc;

   // Only the 5x5 corner of the 3-bit coordinate space is a real board cell.
   assign player_ok       = player_fire && (player_x <= 3'd4) && (player_y <= 3'd4);
   assign cpu_ok          = cpu_valid && (cpu_x <= 3'd4) && (cpu_y <= 3'd4);
   assign hits_player_inc = hits_player + 4'd1;
   assign hits_cpu_inc    = hits_cpu + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         timer_q       <= '0;
         en_put_barcos <= 1'b0;
         cpu_req       <= 1'b0;
         shot_valid    <= 1'b0;
         shot_x        <= 3'd0;
         shot_y        <= 3'd0;
         shot_target   <= 1'b0;
         hits_player   <= 4'd0;
         hits_cpu      <= 4'd0;
         turn          <= 1'b0;
         turn_timeout  <= 1'b0;
         game_over     <= 1'b0;
         winner        <= 1'b0;
      end else begin
         turn_timeout <= 1'b0;
         case (state_q)
            StIdle, StGameOver: begin
               if (start) begin
                  state_q       <= StPlace;
                  en_put_barcos <= 1'b1;
                  hits_player   <= 4'd0;
                  hits_cpu      <= 4'd0;
                  turn          <= 1'b0;
                  game_over     <= 1'b0;
                  winner        <= 1'b0;
               end
            end
            StPlace: begin
               if (end_move_barcos) begin
                  state_q       <= StPlayerTurn;
                  en_put_barcos <= 1'b0;
                  turn          <= 1'b0;
                  timer_q       <= '0;
               end
            end
            StPlayerTurn: begin
               // A valid fire on the expiry cycle takes priority over the forfeit.
               if (player_ok) begin
                  state_q     <= StPlayerShot;
                  shot_valid  <= 1'b1;
                  shot_x      <= player_x;
                  shot_y      <= player_y;
                  shot_target <= 1'b0;
               end else if (timer_q == TIMER_LAST) begin
                  state_q      <= StCpuTurn;
                  cpu_req      <= 1'b1;
                  turn         <= 1'b1;
                  turn_timeout <= 1'b1;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StPlayerShot: begin
               if (shot_done) begin
                  shot_valid <= 1'b0;
                  if (shot_hit) hits_player <= hits_player_inc;
                  if (shot_hit && (hits_player_inc == HIT_WIN)) begin
                     state_q   <= StGameOver;
                     game_over <= 1'b1;
                     winner    <= 1'b0;
                  end else begin
                     state_q <= StCpuTurn;
                     cpu_req <= 1'b1;
                     turn    <= 1'b1;
                  end
               end
            end
            StCpuTurn: begin
               if (cpu_ok) begin
                  state_q     <= StCpuShot;
                  cpu_req     <= 1'b0;
                  shot_valid  <= 1'b1;
                  shot_x      <= cpu_x;
                  shot_y      <= cpu_y;
                  shot_target <= 1'b1;
               end
            end
            StCpuShot: begin
               if (shot_done) begin
                  shot_valid <= 1'b0;
                  if (shot_hit) hits_cpu <= hits_cpu_inc;
                  if (shot_hit && (hits_cpu_inc == HIT_WIN)) begin
                     state_q   <= StGameOver;
                     game_over <= 1'b1;
                     winner    <= 1'b1;
                  end else begin
                     state_q <= StPlayerTurn;
                     turn    <= 1'b0;
                     timer_q <= '0;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
